prom_read_sequencer: RTL and testbench
======================================

# prom_read_sequencer

Upstream read controller for the 16x4 PROM. On a start command it walks a programmable run of PROM addresses, drives the PROM's address and enable inputs, and captures each registered PROM output in the one cycle it is valid. Each word is presented to a downstream consumer over a valid/ready handshake. It sits between the control logic and the PROM, and isolates consumers from the PROM's one-cycle read latency and its undefined output when disabled.

## Interface
Parameters:
- ADDR_W, 4, PROM address width (16 words)
- DATA_W, 4, PROM word width
- LEN_W, 5, width of run-length field

Ports:
- clock  in  1  rising-edge clock shared with the PROM
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- start_addr  in  ADDR_W  first address of the run
- length  in  LEN_W  words to read (0..31)
- rom_address  out  ADDR_W  to PROM address
- rom_enable  out  1  to PROM enable
- rom_data  in  DATA_W  from PROM data_out
- out_data  out  DATA_W  captured word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

## Operation
- One clock domain (clock). Reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values: rom_address=0, rom_enable=0, out_data=0, out_valid=0, busy=0, done=0. The FSM goes to IDLE, and the address and remaining counters clear.
- Reset asserted mid-run aborts the run immediately. No done pulse is generated, and any held word is discarded.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE
  - start=1 with length≠0: latch addr=start_addr and remaining=length, set busy=1, then go to ISSUE.
  - start=1 with length=0: pulse done for one cycle, busy stays 0, stay in IDLE.
- ISSUE: rom_enable=1, rom_address=addr. Next state is CAPTURE.
- CAPTURE: rom_enable=0 and rom_data is valid this cycle. At the closing edge: out_data<=rom_data, out_valid<=1, go to HOLD.
- HOLD
  - out_valid=1 and out_data is held stable until out_ready=1.
  - On handshake: out_valid<=0, addr<=addr+1 (mod 16, so 15 wraps to 0), remaining<=remaining-1.
  - If remaining was 1: busy<=0, done<=1, go to IDLE. Otherwise go to ISSUE.
- rom_data is ignored in every state except CAPTURE. The PROM output is X while disabled, and X must never reach out_data.
- start is ignored while busy=1, including in the done cycle's predecessor states. start sampled in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- A length greater than 16 re-reads addresses after the wrap. For example, length=20 from addr 0 reads 0..15, then 0..3.

## Timing
- start sampled at edge 0:
  - Cycle 1: ISSUE, rom_enable=1.
  - Cycle 2: CAPTURE.
  - Cycle 3: first out_valid=1.
- Minimum 3 cycles per word with out_ready held high. Subsequent out_valid cycles are 6, 9, 12, …
- Each cycle out_ready is low in HOLD adds one cycle. There is no word loss and out_data does not change.
- done is high for exactly one cycle: the cycle after the final handshake edge. busy falls on that same edge.
- rom_enable is high exactly one cycle per word. rom_address only changes on handshake or start.

## Test plan
All scenarios use the team's 16x4 PROM image: addr 0..15 = 2,4,6,8,10,12,14,0,1,3,5,7,9,11,13,15.
- Reset: assert reset for 2 cycles mid-run (start_addr=0, length=8, after 2 words). All outputs are 0 on the next cycle, there is no done, and a fresh start then reads from the new start_addr.
- Basic run: start_addr=0, length=4, out_ready=1. out_data=2,4,6,8 on cycles 3,6,9,12, then done in cycle 13 and busy=0.
- Wrap: start_addr=14, length=4. out_data=13,15,2,4 (addresses 14,15,0,1).
- Backpressure: start_addr=8, length=3, out_ready low for 5 cycles on the second word. out_data=1,3,5 with no drop or duplicate, and out_data stays stable while stalled.
- Zero length: start with length=0 gives done for 1 cycle, busy stays 0, and rom_enable never rises.
- Start-ignore and X-safety:
  - start pulsed during a run is ignored, so the word count equals the original length.
  - out_data is never X with rom_enable=0 between reads.

Source files
------------

// File: rtl/prom_read_sequencer.sv
// Read sequencer for the 16x4 PROM: walks a programmable run of addresses,
// captures each registered PROM word in its valid cycle, and hands it downstream via valid/ready.

module prom_read_sequencer_checker #(
  parameter int DATA_W = 4
) (
  input logic              clock,
  input logic              reset,
  input logic              rom_enable,
  input logic              out_valid,
  input logic              out_ready,
  input logic              busy,
  input logic              done,
  input logic [DATA_W-1:0] out_data
);

  // A stalled word must be held unchanged until accepted.
  hold_stable_a: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  en_single_a: assert property (@(posedge clock) disable iff (reset)
    rom_enable |=> !rom_enable);

  en_busy_a: assert property (@(posedge clock) disable iff (reset)
    rom_enable |-> busy);

  done_idle_a: assert property (@(posedge clock) disable iff (reset)
    done |-> !busy);

endmodule

module prom_read_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [LEN_W-1:0]    remaining_r, remaining_s;
  logic                rom_enable_r, rom_enable_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic                out_valid_r, out_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  // Next-state and next-output decode; rom_data is only looked at in CAPTURE.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    remaining_s  = remaining_r;
    rom_enable_s = 1'b0;
    out_data_s   = out_data_r;
    out_valid_s  = out_valid_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (length != {LEN_W{1'b0}}) begin
            addr_s       = start_addr;
            remaining_s  = length;
            busy_s       = 1'b1;
            rom_enable_s = 1'b1;
            state_s      = ISSUE;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = CAPTURE;
      end
      CAPTURE: begin
        out_data_s  = rom_data;
        out_valid_s = 1'b1;
        state_s     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          addr_s      = addr_r + ADDR_W'(1);
          remaining_s = remaining_r - LEN_W'(1);
          if (remaining_r == LEN_W'(1)) begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            rom_enable_s = 1'b1;
            state_s      = ISSUE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset discards any held word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      remaining_r  <= {LEN_W{1'b0}};
      rom_enable_r <= 1'b0;
      out_data_r   <= {DATA_W{1'b0}};
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      remaining_r  <= remaining_s;
      rom_enable_r <= rom_enable_s;
      out_data_r   <= out_data_s;
      out_valid_r  <= out_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign rom_address = addr_r;
  assign rom_enable  = rom_enable_r;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;

  prom_read_sequencer_checker #(.DATA_W(DATA_W)) u_checker (
    .clock      (clock),
    .reset      (reset),
    .rom_enable (rom_enable_r),
    .out_valid  (out_valid_r),
    .out_ready  (out_ready),
    .busy       (busy_r),
    .done       (done_r),
    .out_data   (out_data_r)
  );

endmodule

// File: tb/tb_prom_read_sequencer.sv
// Directed bench for prom_read_sequencer with a behavioural 16x4 registered PROM
// whose output is junk whenever it is disabled.

module tb_prom_read_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic [3:0] rom_address;
  logic       rom_enable;
  logic [3:0] rom_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] last_data;

  logic [3:0] image [0:15] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0,
                               4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};

  always #5 clock = ~clock;

  // PROM model: one-cycle registered read, garbage while disabled.
  always @(posedge clock) begin
    if (rom_enable) rom_data <= image[rom_address];
    else            rom_data <= 4'($urandom_range(0, 15));
  end

  prom_read_sequencer #(.ADDR_W(4), .DATA_W(4), .LEN_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .rom_address (rom_address),
    .rom_enable  (rom_enable),
    .rom_data    (rom_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [3:0] a, input logic [4:0] n);
    start_addr = a;
    length     = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Entered in the ISSUE cycle; leaves one cycle after the handshake edge.
  task automatic read_word(input logic [3:0] a, input logic [3:0] d, input int stall);
    chk("issue_en", rom_enable, 1);
    chk("issue_addr", rom_address, a);
    chk("issue_busy", busy, 1);
    chk("issue_valid", out_valid, 0);
    chk("issue_keep", out_data, last_data);
    out_ready = (stall == 0);
    step();
    chk("cap_en", rom_enable, 0);
    chk("cap_keep", out_data, last_data);
    step();
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, d);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, d);
      chk("stall_en", rom_enable, 0);
      chk("stall_addr", rom_address, a);
    end
    out_ready = 1'b1;
    last_data = d;
    step();
  endtask

  task automatic chk_done();
    chk("done_hi", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    chk("done_en", rom_enable, 0);
    step();
    chk("done_lo", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = 4'd0; length = 5'd0; out_ready = 1'b1;
    step();
    step();
    chk("rst_addr", rom_address, 0);
    chk("rst_en", rom_enable, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step();
    last_data = 4'd0;

    // Basic run: 2,4,6,8 on cycles 3,6,9,12, done in cycle 13.
    do_start(4'd0, 5'd4);
    read_word(4'd0, 4'd2, 0);
    read_word(4'd1, 4'd4, 0);
    read_word(4'd2, 4'd6, 0);
    read_word(4'd3, 4'd8, 0);
    chk_done();

    // Address wrap 15 -> 0.
    do_start(4'd14, 5'd4);
    read_word(4'd14, 4'd13, 0);
    read_word(4'd15, 4'd15, 0);
    read_word(4'd0, 4'd2, 0);
    read_word(4'd1, 4'd4, 0);
    chk_done();

    // Backpressure: five stalled cycles on the second word.
    do_start(4'd8, 5'd3);
    read_word(4'd8, 4'd1, 0);
    read_word(4'd9, 4'd3, 5);
    read_word(4'd10, 4'd5, 0);
    chk_done();

    // Zero length: done only, nothing read.
    do_start(4'd3, 5'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_en", rom_enable, 0);
    step();
    chk("zero_done_lo", done, 0);
    chk("zero_en2", rom_enable, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_keep", out_data, last_data);

    // start held high during a run is ignored; start in the done cycle is taken.
    start_addr = 4'd2; length = 5'd2; start = 1'b1;
    step();
    start_addr = 4'd9; length = 5'd5;
    read_word(4'd2, 4'd6, 0);
    start = 1'b0;
    read_word(4'd3, 4'd8, 0);
    chk("ign_done", done, 1);
    chk("ign_busy", busy, 0);
    start_addr = 4'd15; length = 5'd1; start = 1'b1;
    step();
    start = 1'b0;
    read_word(4'd15, 4'd15, 0);
    chk_done();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_en", rom_enable, 0);
      chk("idle_busy", busy, 0);
      chk("idle_keep", out_data, 15);
    end

    // Reset two cycles mid-run, after two words of an 8-word run.
    do_start(4'd0, 5'd8);
    read_word(4'd0, 4'd2, 0);
    read_word(4'd1, 4'd4, 0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mrst_addr", rom_address, 0);
      chk("mrst_en", rom_enable, 0);
      chk("mrst_data", out_data, 0);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
    end
    reset = 1'b0;
    step();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_en", rom_enable, 0);
    last_data = 4'd0;
    do_start(4'd5, 5'd2);
    read_word(4'd5, 4'd12, 0);
    read_word(4'd6, 4'd14, 0);
    chk_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
